// File: rtl/dcs_pkg.sv
// Shared types and golden model for the gate-delay circuit sequencer.
// Golden behaviour of the circuit under test: x = (A&B) | ~C, y = ~C.
package dcs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } dcs_state_e;

    localparam logic [2:0] VEC_LAST = 3'd7;

    // vec is {A,B,C}; result is {x,y}
    function automatic logic [1:0] dcs_golden(input logic [2:0] vec);
        return {(vec[2] & vec[1]) | ~vec[0], ~vec[0]};
    endfunction

endpackage

// File: rtl/dcs_settle_timer.sv
// Loadable down-counter that times the settle window of each test vector.
// Counts down to zero and holds there; zero is asserted while the count is 0.
module dcs_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/delay_circuit_sequencer.sv
// Sweeps all eight {A,B,C} vectors into the gate-delay circuit, waits for it to settle,
// and checks x/y against the golden model. Optional macro: DCS_FAIL_CAPTURE_EN.
module delay_circuit_sequencer
    import dcs_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    input  logic             dut_x,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       cur_vec
`ifdef DCS_FAIL_CAPTURE_EN
    ,
    output logic             first_fail_vld,
    output logic [2:0]       first_fail_vec,
    output logic [1:0]       first_fail_xy
`endif
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    dcs_state_e state;
    logic       timer_zero;
    logic       mismatch;
    logic       accept_start;

    // Timer is armed in DRIVE so that SETTLE lasts exactly SETTLE_CYCLES clocks
    dcs_settle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == DRIVE),
        .load_val (TW'(SETTLE_CYCLES - 1)),
        .dec      (state == SETTLE),
        .zero     (timer_zero)
    );

    assign mismatch     = ({dut_x, dut_y} != dcs_golden(cur_vec));
    assign accept_start = start && !abort && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            {dut_a, dut_b, dut_c}   <= 3'b000;
            err_cnt                 <= '0;
            cur_vec                 <= 3'd0;
        end else if (abort) begin
            // err_cnt is deliberately kept so an aborted sweep can still be inspected
            state                   <= IDLE;
            {dut_a, dut_b, dut_c}   <= 3'b000;
            cur_vec                 <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state                 <= DRIVE;
                        cur_vec               <= 3'd0;
                        err_cnt               <= '0;
                        {dut_a, dut_b, dut_c} <= 3'b000;
                    end
                end
                DRIVE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (cur_vec == VEC_LAST) begin
                        state <= DONE;
                    end else begin
                        state                 <= DRIVE;
                        cur_vec               <= cur_vec + 3'd1;
                        {dut_a, dut_b, dut_c} <= cur_vec + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

`ifdef DCS_FAIL_CAPTURE_EN
    // Only the first failure of a sweep is kept; abort leaves it visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= 3'd0;
            first_fail_xy  <= 2'b00;
        end else if (accept_start) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= 3'd0;
            first_fail_xy  <= 2'b00;
        end else if (!abort && (state == SAMPLE) && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= cur_vec;
            first_fail_xy  <= {dut_x, dut_y};
        end
    end
`endif

endmodule

// File: tb/tb_delay_circuit_sequencer.sv
// Bench for delay_circuit_sequencer driving a behavioural gate-delay circuit with injectable faults.
// Two sequencers share the controls: one with an 8-bit counter and one with a 2-bit counter.
module tb_delay_circuit_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    int   fault;

    logic       a0, b0, c0, x0, y0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [2:0] vec0;
    logic       a1, b1, c1, x1, y1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [2:0] vec1;
`ifdef DCS_FAIL_CAPTURE_EN
    logic       ffv0, ffv1;
    logic [2:0] ffvec0, ffvec1;
    logic [1:0] ffxy0, ffxy1;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    logic [2:0] vec_q[$];
    int         err0_q[$];
    int         err1_q[$];

    always #5 clk = ~clk;

    // Gate-delay circuit: AND 30, OR 20, inverter path 20; fault 1 = y stuck 0, 2 = x inverted
    logic and0, xg0, yg0, and1, xg1, yg1;
    assign #30 and0 = a0 & b0;
    assign #20 xg0  = and0 | ~c0;
    assign #20 yg0  = ~c0;
    assign x0 = (fault == 2) ? ~xg0 : xg0;
    assign y0 = (fault == 1) ? 1'b0 : yg0;
    assign #30 and1 = a1 & b1;
    assign #20 xg1  = and1 | ~c1;
    assign #20 yg1  = ~c1;
    assign x1 = (fault == 2) ? ~xg1 : xg1;
    assign y1 = (fault == 1) ? 1'b0 : yg1;

    delay_circuit_sequencer #(.SETTLE_CYCLES(8), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_x(x0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .cur_vec(vec0)
`ifdef DCS_FAIL_CAPTURE_EN
        , .first_fail_vld(ffv0), .first_fail_vec(ffvec0), .first_fail_xy(ffxy0)
`endif
    );

    delay_circuit_sequencer #(.SETTLE_CYCLES(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_x(x1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .cur_vec(vec1)
`ifdef DCS_FAIL_CAPTURE_EN
        , .first_fail_vld(ffv1), .first_fail_vec(ffvec1), .first_fail_xy(ffxy1)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_abc0"},  {a0, b0, c0}, 3'b000);
        check_output({tag, "_flags0"}, {busy0, done0, pass0}, 3'b000);
        check_output({tag, "_err0"},  err0, 0);
        check_output({tag, "_vec0"},  vec0, 0);
        check_output({tag, "_abc1"},  {a1, b1, c1}, 3'b000);
        check_output({tag, "_flags1"}, {busy1, done1, pass1}, 3'b000);
        check_output({tag, "_err1"},  err1, 0);
`ifdef DCS_FAIL_CAPTURE_EN
        check_output({tag, "_ffvld0"}, ffv0, 0);
`endif
    endtask

    // One sweep; glitch_n pulses start at that cycle, abort_n aborts at that cycle (-1 = never)
    task automatic run_sweep(input int fm, input int glitch_n, input int abort_n);
        int         n;
        int         errs;
        int         errs_pre;
        int         ff_vec;
        logic [1:0] ff_xy;
        logic [1:0] gold;
        logic [1:0] obs;
        logic [2:0] v;
        errs = 0; errs_pre = 0; ff_vec = -1; ff_xy = 2'b00;
        fault = fm;
        for (int k = 0; k < 8; k++) begin
            v    = 3'(k);
            gold = {(v[2] & v[1]) | ~v[0], ~v[0]};
            obs  = gold;
            if (fm == 2) obs[1] = ~gold[1];
            if (fm == 1) obs[0] = 1'b0;
            vec_q.push_back(v);
            if (obs != gold) begin
                errs++;
                if (abort_n >= 0 && 10 * k + 10 <= abort_n) errs_pre++;
                if (ff_vec < 0) begin
                    ff_vec = k;
                    ff_xy  = obs;
                end
            end
        end
        err0_q.push_back((abort_n >= 0) ? errs_pre : errs);
        err1_q.push_back(((abort_n >= 0) ? errs_pre : errs) > 3 ? 3 : ((abort_n >= 0) ? errs_pre : errs));

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            if (n % 10 == 4 && vec_q.size() > 0) begin
                v = vec_q.pop_front();
                check_output($sformatf("vec%0d_abc", v), {a0, b0, c0}, v);
                check_output($sformatf("vec%0d_cur", v), vec0, v);
                check_output($sformatf("vec%0d_busy", v), busy0, 1);
            end
            if (n == abort_n) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_output("abort_flags", {busy0, done0, busy1, done1}, 4'b0000);
                check_output("abort_abc", {a0, b0, c0}, 3'b000);
                check_output("abort_vec", vec0, 0);
                check_output("abort_err0", err0, err0_q.pop_front());
                check_output("abort_err1", err1, err1_q.pop_front());
`ifdef DCS_FAIL_CAPTURE_EN
                if (ff_vec >= 0 && 10 * ff_vec + 10 <= abort_n) begin
                    check_output("abort_ffvld", ffv0, 1);
                    check_output("abort_ffvec", ffvec0, ff_vec);
                end
`endif
                vec_q.delete();
                return;
            end
            start = (n == glitch_n);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_output("done_latency", n, 80);
        check_output("done_flags", {done0, busy0}, 2'b10);
        check_output("done_vec", vec0, 7);
        check_output("done_abc", {a0, b0, c0}, 3'b111);
        check_output("done_err0", err0, err0_q.pop_front());
        check_output("done_pass0", pass0, (errs == 0));
        check_output("done_err1", err1, err1_q.pop_front());
        check_output("done_pass1", pass1, (errs == 0));
`ifdef DCS_FAIL_CAPTURE_EN
        check_output("ff_vld", ffv0, (ff_vec >= 0));
        if (ff_vec >= 0) begin
            check_output("ff_vec", ffvec0, ff_vec);
            check_output("ff_xy", ffxy0, ff_xy);
        end
`endif
        repeat (5) @(negedge clk);
        check_output("done_hold", {done0, vec0, pass0}, {1'b1, 3'd7, (errs == 0)});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; fault = 0;
        #12;
        check_reset_state("reset");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_reset_state("post_reset");

        $display("[TB] correct circuit sweep");
        run_sweep(0, -1, -1);

        $display("[TB] y stuck at 0");
        run_sweep(1, -1, -1);

        $display("[TB] x inverted, 2-bit counter saturates");
        run_sweep(2, -1, -1);

        $display("[TB] abort in SETTLE of vec 3");
        run_sweep(1, -1, 33);

        $display("[TB] start+abort together in IDLE");
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check_output("idle_start_abort_busy", busy0, 0);
        repeat (3) @(negedge clk);
        check_output("idle_start_abort_hold", {busy0, done0}, 2'b00);

        $display("[TB] restart after abort, start pulse during SAMPLE of vec 5");
        run_sweep(0, 59, -1);

        $display("[TB] asynchronous reset mid-SETTLE");
        fault = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (25) @(negedge clk);
        check_output("pre_rst_busy", busy0, 1);
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_reset_state("after_async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
